// File: rtl/sc_collatz_datapath.sv
// sc_collatz_datapath
// Datapath that answers the Collatz control FSM. Every cycle it applies the
// incoming control word:
//   - the BUSA source select
//   - the ALU operation
//   - the result shift register load (REGSHIFTER, which drives BUSC)
//   - the Reg0..Reg2 load decoder
// It returns the active-low zero flag that the FSM branches on.
// Optional statistics (step count, peak value, sticky 3N+1 overflow) are built
// only when the macro SC_DATAPATH_STATS_EN is defined. Without the macro those
// outputs are tied to zero and no statistics registers exist.
module sc_collatz_datapath #(
  parameter int DATAWIDTH_BUS               = 8,
  parameter int DATAWIDTH_DECODER_SELECTION = 2,
  parameter int DATAWIDTH_MUX_SELECTION     = 2,
  parameter int DATAWIDTH_ALU_SELECTION     = 3,
  parameter int DATAWIDTH_STEPS             = 8
) (
  input  logic                                   SC_DATAPATH_CLOCK_50,
  input  logic                                   SC_DATAPATH_RESET_InLow,
  input  logic [DATAWIDTH_DECODER_SELECTION-1:0] SC_DATAPATH_decoderloadselection_InBUS,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]     SC_DATAPATH_muxselectionBUSA_InBUS,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0]     SC_DATAPATH_aluselection_InBUS,
  input  logic                                   SC_DATAPATH_regSHIFTERload_InLow,
  input  logic [DATAWIDTH_BUS-1:0]               SC_DATAPATH_entryvalue_InBUS,
  output logic                                   SC_DATAPATH_zero_OutLow,
  output logic [DATAWIDTH_BUS-1:0]               SC_DATAPATH_data_OutBUS,
  output logic [DATAWIDTH_STEPS-1:0]             SC_DATAPATH_steps_OutBUS,
  output logic [DATAWIDTH_BUS-1:0]               SC_DATAPATH_peak_OutBUS,
  output logic                                   SC_DATAPATH_overflow_OutHigh
);

  localparam int W = DATAWIDTH_BUS;

  localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
  localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W+1:0]   ONE_WIDE = {{(W+1){1'b0}}, 1'b1};

  // Parity word: the LSB of the operand in bit 0, so an even operand gives 0.
  function automatic logic [W-1:0] parity_word(input logic [W-1:0] value);
    parity_word = {{(W-1){1'b0}}, value[0]};
  endfunction

  logic [W-1:0]   reg0_r;
  logic [W-1:0]   reg1_r;
  logic [W-1:0]   reg2_r;
  logic [W-1:0]   shifter_r;
  logic [W-1:0]   bus_a_s;
  logic [W-1:0]   bus_c_s;
  logic [W+1:0]   alu_wide_s;
  logic [W-1:0]   alu_result_s;
  logic           alu_carry_s;
  logic           shifter_load_s;

  assign bus_c_s        = shifter_r;
  assign shifter_load_s = ~SC_DATAPATH_regSHIFTERload_InLow;

  // BUSA source selection: Reg0, entry value, Reg1 or constant zero.
  always_comb begin
    bus_a_s = ZERO_W;
    case (SC_DATAPATH_muxselectionBUSA_InBUS)
      2'b00:   bus_a_s = reg0_r;
      2'b01:   bus_a_s = SC_DATAPATH_entryvalue_InBUS;
      2'b10:   bus_a_s = reg1_r;
      2'b11:   bus_a_s = ZERO_W;
      default: bus_a_s = ZERO_W;
    endcase
  end

  // ALU evaluated two bits wider than the bus so 3N+1 keeps its carry-out.
  always_comb begin
    alu_wide_s = {2'b00, bus_a_s};
    case (SC_DATAPATH_aluselection_InBUS)
      3'b000:  alu_wide_s = {3'b000, bus_a_s[W-1:1]};
      3'b001:  alu_wide_s = ({2'b00, bus_a_s} + {1'b0, bus_a_s, 1'b0}) + ONE_WIDE;
      3'b010:  alu_wide_s = {2'b00, bus_a_s - ONE_W};
      3'b011:  alu_wide_s = {2'b00, parity_word(bus_a_s)};
      default: alu_wide_s = {2'b00, bus_a_s};
    endcase
  end

  assign alu_result_s = alu_wide_s[W-1:0];
  // Only 3N+1 can set the upper bits; the other ops zero-extend.
  assign alu_carry_s  = |alu_wide_s[W+1:W];

  // The FSM needs the zero flag in the same cycle as the control word.
  assign SC_DATAPATH_zero_OutLow = |alu_result_s;

  // Result shift register: captures the ALU result on an active-low load.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow) begin
      shifter_r <= ZERO_W;
    end else if (shifter_load_s) begin
      shifter_r <= alu_result_s;
    end else begin
      shifter_r <= shifter_r;
    end
  end

  // Register file load from BUSC; BUSC is the pre-edge shifter value.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow) begin
      reg0_r <= ZERO_W;
      reg1_r <= ZERO_W;
      reg2_r <= ZERO_W;
    end else begin
      case (SC_DATAPATH_decoderloadselection_InBUS)
        2'b00:   reg0_r <= bus_c_s;
        2'b01:   reg1_r <= bus_c_s;
        2'b10:   reg2_r <= bus_c_s;
        default: begin
          reg0_r <= reg0_r;
          reg1_r <= reg1_r;
          reg2_r <= reg2_r;
        end
      endcase
    end
  end

  assign SC_DATAPATH_data_OutBUS = reg0_r;

`ifdef SC_DATAPATH_STATS_EN
  localparam logic [DATAWIDTH_STEPS-1:0] STEPS_ZERO = {DATAWIDTH_STEPS{1'b0}};
  localparam logic [DATAWIDTH_STEPS-1:0] STEPS_ONE  = {{(DATAWIDTH_STEPS-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH_STEPS-1:0] STEPS_MAX  = {DATAWIDTH_STEPS{1'b1}};

  logic [DATAWIDTH_STEPS-1:0] steps_r;
  logic [W-1:0]               peak_r;
  logic                       overflow_r;
  logic                       step_op_s;
  logic                       reg0_load_s;

  // Only halving and 3N+1 count as Collatz steps.
  assign step_op_s   = (SC_DATAPATH_aluselection_InBUS == 3'b000) ||
                       (SC_DATAPATH_aluselection_InBUS == 3'b001);
  assign reg0_load_s = (SC_DATAPATH_decoderloadselection_InBUS == 2'b00);

  // Saturating step counter, advanced on each shifter load of a step op.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow) begin
      steps_r <= STEPS_ZERO;
    end else if (shifter_load_s && step_op_s && (steps_r != STEPS_MAX)) begin
      steps_r <= steps_r + STEPS_ONE;
    end else begin
      steps_r <= steps_r;
    end
  end

  // Peak tracks the largest value written into Reg0.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow) begin
      peak_r <= ZERO_W;
    end else if (reg0_load_s && (bus_c_s > peak_r)) begin
      peak_r <= bus_c_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  // Sticky overflow: a captured 3N+1 result lost bits above the bus width.
  always_ff @(posedge SC_DATAPATH_CLOCK_50) begin
    if (!SC_DATAPATH_RESET_InLow) begin
      overflow_r <= 1'b0;
    end else if (shifter_load_s && (SC_DATAPATH_aluselection_InBUS == 3'b001) && alu_carry_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign SC_DATAPATH_steps_OutBUS     = steps_r;
  assign SC_DATAPATH_peak_OutBUS      = peak_r;
  assign SC_DATAPATH_overflow_OutHigh = overflow_r;
`else
  logic stats_unused_s;

  assign stats_unused_s               = alu_carry_s;
  assign SC_DATAPATH_steps_OutBUS     = {DATAWIDTH_STEPS{1'b0}};
  assign SC_DATAPATH_peak_OutBUS      = ZERO_W;
  assign SC_DATAPATH_overflow_OutHigh = 1'b0;
`endif

endmodule

// File: tb/tb_sc_collatz_datapath.sv
// Testbench for sc_collatz_datapath.
// The reference model keeps the architectural state as plain integers. Each
// cycle it derives the ALU result with ordinary arithmetic. Collatz runs are
// also traced against an independent integer Collatz iteration.
// Statistics expectations collapse to zero unless SC_DATAPATH_STATS_EN is set.
module tb_sc_collatz_datapath;

  localparam int W    = 8;
  localparam int S    = 8;
  localparam int MODW = 1 << W;
  localparam int MAXS = (1 << S) - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     dec;
  logic [1:0]     mux;
  logic [2:0]     alu;
  logic           ld_n;
  logic [W-1:0]   entry;
  logic           zero_n;
  logic [W-1:0]   data;
  logic [S-1:0]   steps;
  logic [W-1:0]   peak;
  logic           ovf;

  int n_checks = 0;
  int n_fail   = 0;

  int m_reg[3];
  int m_sh;
  int m_steps;
  int m_peak;
  int m_ovf;

  always #5 clk = ~clk;

  sc_collatz_datapath dut (
    .SC_DATAPATH_CLOCK_50                   (clk),
    .SC_DATAPATH_RESET_InLow                (rst_n),
    .SC_DATAPATH_decoderloadselection_InBUS (dec),
    .SC_DATAPATH_muxselectionBUSA_InBUS     (mux),
    .SC_DATAPATH_aluselection_InBUS         (alu),
    .SC_DATAPATH_regSHIFTERload_InLow       (ld_n),
    .SC_DATAPATH_entryvalue_InBUS           (entry),
    .SC_DATAPATH_zero_OutLow                (zero_n),
    .SC_DATAPATH_data_OutBUS                (data),
    .SC_DATAPATH_steps_OutBUS               (steps),
    .SC_DATAPATH_peak_OutBUS                (peak),
    .SC_DATAPATH_overflow_OutHigh           (ovf)
  );

  function automatic int stat(input int v);
`ifdef SC_DATAPATH_STATS_EN
    return v;
`else
    return 0;
`endif
  endfunction

  function automatic int busa_model(input int sel, input int e);
    case (sel)
      0:       return m_reg[0];
      1:       return e % MODW;
      2:       return m_reg[1];
      default: return 0;
    endcase
  endfunction

  function automatic int alu_model(input int a, input int op);
    case (op)
      0:       return a / 2;
      1:       return (3 * a + 1) % MODW;
      2:       return (a == 0) ? MODW - 1 : a - 1;
      3:       return a % 2;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_data"},  data,  m_reg[0]);
    chk({tag, "_steps"}, steps, stat(m_steps));
    chk({tag, "_peak"},  peak,  stat(m_peak));
    chk({tag, "_ovf"},   ovf,   stat(m_ovf));
  endtask

  task automatic model_clear();
    m_reg[0] = 0; m_reg[1] = 0; m_reg[2] = 0;
    m_sh = 0; m_steps = 0; m_peak = 0; m_ovf = 0;
  endtask

  // One control word: zero flag checked before the edge, state after it.
  task automatic cyc(input logic [1:0] d, input logic [1:0] m, input logic [2:0] a,
                     input logic l, input int e);
    int busa;
    int r;
    int busc;
    @(negedge clk);
    dec = d; mux = m; alu = a; ld_n = l; entry = e[W-1:0];
    busa = busa_model(int'(m), e);
    r    = alu_model(busa, int'(a));
    #1;
    chk("zero_n", zero_n, (r != 0) ? 1 : 0);
    @(posedge clk);
    busc = m_sh;
    if (l == 1'b0) begin
      m_sh = r;
      if ((a == 3'b000 || a == 3'b001) && m_steps < MAXS) m_steps++;
      if (a == 3'b001 && (3 * busa + 1) >= MODW) m_ovf = 1;
    end
    if (d != 2'b11) begin
      m_reg[d] = busc;
      if (d == 2'b00 && busc > m_peak) m_peak = busc;
    end
    #1;
    chk_state("cyc");
  endtask

  // One reset edge with loads requested, to show reset wins.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; dec = 2'b00; mux = 2'b01; alu = 3'b001; ld_n = 1'b0; entry = 8'd255;
    @(posedge clk);
    model_clear();
    #1;
    chk_state("reset");
    rst_n = 1'b1;
  endtask

  // FSM-style Collatz run; stops at 1 or after max_steps steps.
  task automatic run_collatz(input int start, input int max_steps);
    int n;
    int cnt;
    n   = start;
    cnt = 0;
    cyc(2'b11, 2'b01, 3'b100, 1'b0, start);
    cyc(2'b00, 2'b11, 3'b100, 1'b1, start);
    chk("trace", data, n);
    for (int k = 0; k < 300; k++) begin
      if (cnt == max_steps) break;
      cyc(2'b11, 2'b00, 3'b010, 1'b1, start);
      if (n == 1) break;
      cyc(2'b11, 2'b00, 3'b011, 1'b1, start);
      if (n % 2 == 0) begin
        cyc(2'b11, 2'b00, 3'b000, 1'b0, start);
        n = n / 2;
      end else begin
        cyc(2'b11, 2'b00, 3'b001, 1'b0, start);
        n = 3 * n + 1;
      end
      cyc(2'b00, 2'b11, 3'b100, 1'b1, start);
      cnt++;
      chk("trace", data, n % MODW);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; dec = 2'b11; mux = 2'b11; alu = 3'b100; ld_n = 1'b1; entry = '0;
    model_clear();
    do_reset();
    // Reset state with the constant-zero source.
    cyc(2'b11, 2'b11, 3'b100, 1'b1, 0);
    chk("rst_zero_mux11", zero_n, 0);

    // Entry 6.
    run_collatz(6, 1000);
    chk("e6_data",  data,  1);
    chk("e6_steps", steps, stat(8));
    chk("e6_peak",  peak,  stat(16));

    // Entry 7.
    do_reset();
    run_collatz(7, 1000);
    chk("e7_data",  data,  1);
    chk("e7_steps", steps, stat(16));
    chk("e7_peak",  peak,  stat(52));
    chk("e7_ovf",   ovf,   0);

    // Entry 1: the first decrement already gives zero.
    do_reset();
    run_collatz(1, 1000);
    chk("e1_steps", steps, stat(0));
    chk("e1_peak",  peak,  stat(1));

    // Entry 171 under 3N+1 wraps to 2 and sets the sticky overflow.
    do_reset();
    cyc(2'b11, 2'b01, 3'b001, 1'b0, 171);
    cyc(2'b00, 2'b11, 3'b100, 1'b1, 171);
    chk("e171_data", data, 2);
    chk("e171_ovf",  ovf,  stat(1));
    cyc(2'b11, 2'b00, 3'b000, 1'b0, 0);
    cyc(2'b11, 2'b00, 3'b010, 1'b0, 0);
    cyc(2'b00, 2'b11, 3'b100, 1'b1, 0);
    chk("e171_ovf_sticky", ovf, stat(1));
    do_reset();
    chk("e171_ovf_cleared", ovf, 0);

    // Decrement of zero wraps; parity of 4 is zero.
    cyc(2'b11, 2'b00, 3'b010, 1'b1, 0);
    chk("dec0_zero_n", zero_n, 1);
    cyc(2'b11, 2'b01, 3'b100, 1'b0, 4);
    cyc(2'b00, 2'b11, 3'b100, 1'b1, 4);
    cyc(2'b11, 2'b00, 3'b011, 1'b1, 4);
    cyc(2'b11, 2'b00, 3'b010, 1'b0, 4);
    cyc(2'b01, 2'b11, 3'b100, 1'b1, 0);
    cyc(2'b11, 2'b10, 3'b100, 1'b1, 0);
    chk("reg1_path", zero_n, 1);

    // Simultaneous shifter load and Reg0 load: Reg0 gets the old shifter.
    do_reset();
    cyc(2'b11, 2'b01, 3'b100, 1'b0, 33);
    cyc(2'b00, 2'b01, 3'b100, 1'b0, 77);
    chk("old_busc", data, 33);
    cyc(2'b00, 2'b11, 3'b100, 1'b1, 0);
    chk("new_busc", data, 77);

    // Mid-sequence reset: reach Reg0=10 with three steps from 12.
    do_reset();
    run_collatz(12, 3);
    chk("mid_data",  data,  10);
    chk("mid_steps", steps, stat(3));
    @(negedge clk);
    dec = 2'b11; ld_n = 1'b1;
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    cyc(2'b11, 2'b11, 3'b100, 1'b1, 0);
    chk("glitch_data",  data,  10);
    chk("glitch_steps", steps, stat(3));
    do_reset();
    chk("mid_rst_data",  data,  0);
    chk("mid_rst_steps", steps, 0);
    chk("mid_rst_peak",  peak,  0);

    // Step counter saturation.
    for (int i = 0; i < 260; i++) cyc(2'b11, 2'b01, 3'b000, 1'b0, 2);
    chk("steps_sat", steps, stat(MAXS));

    // Randomized control words.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        cyc(2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, MODW - 1)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
